serial_transmitter_d: RTL and testbench

Transmit end of the team's serial D-line link. Loads a parallel word and shifts it out on one line as a frame: start bit, data bits LSB first, stop bit. Frame output feeds a receiver built from negative-edge D flip-flops. All outputs launch on the rising edge of Ck, so each bit is stable at the receiver's falling-edge capture point.

---
 rtl/serial_transmitter_d.sv | 184 ++++++++++++++++++
 tb/tb_serial_transmitter_d.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/serial_transmitter_d.sv
// Serial D-line transmitter: start bit, WIDTH data bits LSB first, stop bit, each held DIV clocks.
// Optional build macro PARITY_TX_EN inserts an even-parity bit between the data and stop bits.
module serial_transmitter_d #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             Ck,
  input  logic             Rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic             Ready,
  output logic             Busy,
  output logic             TxD,
  output logic             Done
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef PARITY_TX_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd3
  } state_t;

`ifdef PARITY_TX_EN
  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    return ^word;
  endfunction
`endif

  state_t             state_r, state_s;
  logic [DIV_W-1:0]   div_r, div_s;
  logic [BIT_W-1:0]   bit_r, bit_s;
  logic [WIDTH-1:0]   shift_r, shift_s, shift_nxt_s;
  logic               txd_r, txd_s;
  logic               ready_r, ready_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               bit_end_s;
`ifdef PARITY_TX_EN
  logic               parity_r, parity_s;
`endif

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_s     = state_r;
    div_s       = div_r;
    bit_s       = bit_r;
    shift_s     = shift_r;
    txd_s       = txd_r;
    ready_s     = ready_r;
    busy_s      = busy_r;
    done_s      = 1'b0;
`ifdef PARITY_TX_EN
    parity_s    = parity_r;
`endif
    bit_end_s   = (div_r == DIV_LAST);
    shift_nxt_s = shift_r >> 1'b1;
    case (state_r)
      IDLE: begin
        if (Load) begin
          state_s  = START;
          shift_s  = Din;
          txd_s    = 1'b0;
          ready_s  = 1'b0;
          busy_s   = 1'b1;
          div_s    = '0;
          bit_s    = '0;
`ifdef PARITY_TX_EN
          parity_s = even_parity(Din);
`endif
        end else begin
          txd_s   = 1'b1;
          ready_s = 1'b1;
          busy_s  = 1'b0;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_s = DATA;
          txd_s   = shift_r[0];
          div_s   = '0;
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end_s) begin
          div_s   = '0;
          shift_s = shift_nxt_s;
          if (bit_r == BIT_LAST) begin
            bit_s   = '0;
`ifdef PARITY_TX_EN
            state_s = PARITY;
            txd_s   = parity_r;
`else
            state_s = STOP;
            txd_s   = 1'b1;
`endif
          end else begin
            bit_s = bit_r + BIT_W'(1);
            txd_s = shift_nxt_s[0];
          end
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
`ifdef PARITY_TX_EN
      PARITY: begin
        if (bit_end_s) begin
          state_s = STOP;
          txd_s   = 1'b1;
          div_s   = '0;
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
`endif
      STOP: begin
        // Done rises together with Ready so a new Load is taken on the following edge.
        if (bit_end_s) begin
          state_s = IDLE;
          txd_s   = 1'b1;
          ready_s = 1'b1;
          busy_s  = 1'b0;
          done_s  = 1'b1;
          div_s   = '0;
        end else begin
          div_s = div_r + DIV_W'(1);
        end
      end
      default: begin
        state_s = IDLE;
        txd_s   = 1'b1;
        ready_s = 1'b1;
        busy_s  = 1'b0;
        div_s   = '0;
        bit_s   = '0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight without a Done pulse.
  always_ff @(posedge Ck or posedge Rst) begin
    if (Rst) begin
      state_r  <= IDLE;
      div_r    <= '0;
      bit_r    <= '0;
      shift_r  <= '0;
      txd_r    <= 1'b1;
      ready_r  <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
`ifdef PARITY_TX_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      div_r    <= div_s;
      bit_r    <= bit_s;
      shift_r  <= shift_s;
      txd_r    <= txd_s;
      ready_r  <= ready_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
`ifdef PARITY_TX_EN
      parity_r <= parity_s;
`endif
    end
  end

  assign Ready = ready_r;
  assign Busy  = busy_r;
  assign TxD   = txd_r;
  assign Done  = done_r;

endmodule

// File: tb/tb_serial_transmitter_d.sv
// Directed bench for serial_transmitter_d: DIV=4 instance driven from a vector table,
// plus a DIV=1 instance and a mid-frame reset sequence checked by hand.
module tb_serial_transmitter_d;

  localparam int W = 8;
  localparam int D = 4;
`ifdef PARITY_TX_EN
  localparam int NB = W + 3;
  localparam bit HAS_PAR = 1'b1;
`else
  localparam int NB = W + 2;
  localparam bit HAS_PAR = 1'b0;
`endif
  localparam int LEN  = NB * D;
  localparam int LEN1 = NB;

  logic         Ck = 1'b0;
  logic         Rst = 1'b1;
  logic         Load = 1'b0;
  logic [W-1:0] Din = 8'h00;
  logic         Ready, Busy, TxD, Done;
  logic         Load1 = 1'b0;
  logic [W-1:0] Din1 = 8'h00;
  logic         Ready1, Busy1, TxD1, Done1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] din;
    logic       par;
    bit         hold;
    int         intr;
  } vec_t;

  vec_t vecs[5];

  serial_transmitter_d #(.WIDTH(W), .DIV(D)) u_dut (
    .Ck(Ck), .Rst(Rst), .Load(Load), .Din(Din),
    .Ready(Ready), .Busy(Busy), .TxD(TxD), .Done(Done)
  );

  serial_transmitter_d #(.WIDTH(W), .DIV(1)) u_dut1 (
    .Ck(Ck), .Rst(Rst), .Load(Load1), .Din(Din1),
    .Ready(Ready1), .Busy(Busy1), .TxD(TxD1), .Done(Done1)
  );

  always #5 Ck = ~Ck;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Sends one frame starting at a negedge with the DUT idle; returns at the Done negedge.
  task automatic run_frame(input vec_t v);
    int   bp;
    logic exp;
    Din  = v.din;
    Load = 1'b1;
    for (int c = 0; c <= LEN; c++) begin
      @(posedge Ck);
      @(negedge Ck);
      if (c < LEN) begin
        bp = c / D;
        if (bp == 0) exp = 1'b0;
        else if (bp <= W) exp = v.din[bp-1];
        else if (HAS_PAR && bp == W + 1) exp = v.par;
        else exp = 1'b1;
        check("txd", TxD, exp);
        check("busy", Busy, 1'b1);
        check("ready", Ready, 1'b0);
        check("done_low", Done, 1'b0);
      end else begin
        check("done_pulse", Done, 1'b1);
        check("ready_end", Ready, 1'b1);
        check("busy_end", Busy, 1'b0);
        check("txd_idle", TxD, 1'b1);
      end
      if (c == 0 && !v.hold) Load = 1'b0;
      if (v.intr > 0 && c == v.intr) begin
        Load = 1'b1;
        Din  = 8'hFF;
      end
      if (v.intr > 0 && c == v.intr + 1) Load = 1'b0;
    end
  endtask

  initial begin
    int done_seen;
    vecs[0] = '{8'hA5, 1'b0, 1'b0, -1};
    vecs[1] = '{8'hA5, 1'b0, 1'b0, 13};
    vecs[2] = '{8'h3C, 1'b0, 1'b1, -1};
    vecs[3] = '{8'hC3, 1'b0, 1'b1, -1};
    vecs[4] = '{8'h07, 1'b1, 1'b0, -1};

    #12;
    check("rst_txd", TxD, 1'b1);
    check("rst_ready", Ready, 1'b1);
    check("rst_busy", Busy, 1'b0);
    check("rst_done", Done, 1'b0);
    @(negedge Ck);
    Rst = 1'b0;
    @(negedge Ck);

    for (int i = 0; i < 5; i++) begin
      if (!(vecs[i].hold && i > 0 && vecs[i-1].hold)) begin
        Load = 1'b0;
        @(posedge Ck);
        @(negedge Ck);
        check("gap_done", Done, 1'b0);
        check("gap_ready", Ready, 1'b1);
        check("gap_txd", TxD, 1'b1);
      end
      run_frame(vecs[i]);
    end
    Load = 1'b0;
    @(negedge Ck);

    // DIV=1, all-zero word: line low through start, data (and parity), then stop.
    Din1  = 8'h00;
    Load1 = 1'b1;
    for (int c = 0; c <= LEN1; c++) begin
      @(posedge Ck);
      @(negedge Ck);
      Load1 = 1'b0;
      check("div1_txd", TxD1, (c >= LEN1 - 1) ? 1'b1 : 1'b0);
      check("div1_done", Done1, (c == LEN1) ? 1'b1 : 1'b0);
      check("div1_busy", Busy1, (c < LEN1) ? 1'b1 : 1'b0);
    end
    @(negedge Ck);
    check("div1_done_drop", Done1, 1'b0);

    // Reset in the middle of the data bits abandons the frame.
    Din  = 8'hA5;
    Load = 1'b1;
    @(posedge Ck);
    @(negedge Ck);
    Load = 1'b0;
    repeat (10) @(negedge Ck);
    check("pre_rst_busy", Busy, 1'b1);
    #2 Rst = 1'b1;
    #1;
    check("mid_rst_txd", TxD, 1'b1);
    check("mid_rst_ready", Ready, 1'b1);
    check("mid_rst_busy", Busy, 1'b0);
    check("mid_rst_done", Done, 1'b0);
    @(negedge Ck);
    Rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < LEN + 10; c++) begin
      @(negedge Ck);
      if (Done) done_seen++;
    end
    check("abort_no_done", (done_seen == 0) ? 1'b1 : 1'b0, 1'b1);
    check("post_rst_ready", Ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
